// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands in a DEPTH-entry FIFO and issues them one at a time to an
// external combinational ALU; optional result model enabled by ALU_CMD_ISSUER_SELFCHECK_EN.
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [2:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [2:0] rsp_op,
    output logic       busy,
    output logic       chk_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    state_t        state_reg;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [10:0] head;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    // Pop decisions use the pre-edge count, so a same-edge push is never popped.
    assign pop       = !empty && ((state_reg == IDLE) || (state_reg == RESP && rsp_ready));
    assign head      = mem[rd_ptr_reg];
    assign busy      = !empty || (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        {alu_op, alu_a, alu_b} <= head;
                        state_reg              <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_op     <= alu_op;
                    rsp_valid  <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    // alu_* and rsp_* are held untouched until the consumer takes the response.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (!empty) begin
                            {alu_op, alu_a, alu_b} <= head;
                            state_reg              <= ISSUE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ALU_CMD_ISSUER_SELFCHECK_EN
    logic [3:0] model_result;
    logic       chk_err_reg;

    always_comb begin
        model_result = 4'h0;
        case (alu_op)
            3'b000:  model_result = alu_a + alu_b;
            3'b001:  model_result = alu_a - alu_b;
            3'b010:  model_result = alu_a & alu_b;
            3'b011:  model_result = alu_a | alu_b;
            3'b100:  model_result = alu_a ^ alu_b;
            3'b101:  model_result = ~alu_a;
            3'b110:  model_result = ~(alu_a & alu_b);
            default: model_result = ~(alu_a | alu_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_reg <= 1'b0;
        end else if (state_reg == ISSUE && alu_result != model_result) begin
            chk_err_reg <= 1'b1;
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: driver queues expected {op,result}, monitor
// checks each response handshake in order. Honours ALU_CMD_ISSUER_SELFCHECK_EN.
module tb_alu_cmd_issuer;
    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic       busy;
    logic       chk_err;

    logic       stub_bug;
    logic [3:0] stub_res;

`ifdef ALU_CMD_ISSUER_SELFCHECK_EN
    localparam int EXP_CHK = 1;
`else
    localparam int EXP_CHK = 0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .busy       (busy),
        .chk_err    (chk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External ALU stub; stub_bug corrupts one specific operation.
    always_comb begin
        stub_res = 4'h0;
        case (alu_op)
            3'b000:  stub_res = alu_a + alu_b;
            3'b001:  stub_res = alu_a - alu_b;
            3'b010:  stub_res = alu_a & alu_b;
            3'b011:  stub_res = alu_a | alu_b;
            3'b100:  stub_res = alu_a ^ alu_b;
            3'b101:  stub_res = ~alu_a;
            3'b110:  stub_res = ~(alu_a & alu_b);
            default: stub_res = ~(alu_a | alu_b);
        endcase
        if (stub_bug && alu_op == 3'b011 && alu_a == 4'h3 && alu_b == 4'h4) begin
            stub_res = 4'h0;
        end
    end
    assign alu_result = stub_res;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the command is accepted at the following posedge if cmd_ready.
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp, output bit acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        acc       = cmd_ready;
        if (acc) begin
            exp_q.push_back({op, exp});
        end
        $display("cmd op=%0d a=%0h b=%0h accepted=%0d", op, a, b, acc);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            #2;
            if (!busy && exp_q.size() == 0) done = 1;
        end
        chk("drain_timeout", int'(done), 1);
    endtask

    // Monitor: a response handshake will occur at the next posedge.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && rsp_valid && rsp_ready) begin
                $display("rsp op=%0d result=%0h", rsp_op, rsp_result);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_op", int'(rsp_op), int'(e[6:4]));
                    chk("rsp_result", int'(rsp_result), int'(e[3:0]));
                end
            end
        end
    end

    initial begin
        bit acc;
        int n_acc;
        bit got;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        stub_bug  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_result", int'(rsp_result), 0);
        chk("rst_rsp_op", int'(rsp_op), 0);
        chk("rst_alu", int'({alu_op, alu_a, alu_b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_chk_err", int'(chk_err), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);

        // Latency: ADD 9+8 -> 1
        rsp_ready = 1'b1;
        send(3'b000, 4'h9, 4'h8, 4'h1, acc);
        chk("lat_alu_a_before", int'(alu_a), 0);
        @(negedge clk);
        chk("lat_alu_a", int'(alu_a), 9);
        chk("lat_alu_b", int'(alu_b), 8);
        chk("lat_alu_op", int'(alu_op), 0);
        chk("lat_rsp_valid_early", int'(rsp_valid), 0);
        @(negedge clk);
        chk("lat_rsp_valid", int'(rsp_valid), 1);
        wait_idle();

        // Operation vectors, back to back
        send(3'b101, 4'b1010, 4'hF, 4'b0101, acc);
        send(3'b001, 4'h2, 4'h5, 4'hD, acc);
        send(3'b011, 4'h3, 4'h4, 4'h7, acc);
        send(3'b100, 4'h6, 4'h3, 4'h5, acc);
        send(3'b110, 4'hF, 4'hF, 4'h0, acc);
        send(3'b111, 4'h0, 4'h0, 4'hF, acc);
        send(3'b000, 4'hF, 4'h1, 4'h0, acc);
        wait_idle();
        chk("alu_retained_a", int'(alu_a), 4'hF);
        chk("alu_retained_b", int'(alu_b), 4'h1);
        chk("chk_err_clean", int'(chk_err), 0);

        // Hold while stalled: AND C&A -> 8
        rsp_ready = 1'b0;
        send(3'b010, 4'hC, 4'hA, 4'h8, acc);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (rsp_valid) got = 1;
            else @(negedge clk);
        end
        chk("hold_rsp_valid_seen", int'(got), 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp", int'({rsp_valid, rsp_op, rsp_result}), int'({1'b1, 3'b010, 4'h8}));
            chk("hold_alu", int'({alu_op, alu_a, alu_b}), int'({3'b010, 4'hC, 4'hA}));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_idle();

        // Capacity: DEPTH queued + one in flight
        rsp_ready = 1'b0;
        n_acc = 0;
        send(3'b000, 4'h1, 4'h2, 4'h3, acc); n_acc += int'(acc);
        send(3'b001, 4'h7, 4'h3, 4'h4, acc); n_acc += int'(acc);
        send(3'b010, 4'h6, 4'h3, 4'h2, acc); n_acc += int'(acc);
        send(3'b011, 4'h8, 4'h1, 4'h9, acc); n_acc += int'(acc);
        send(3'b100, 4'hF, 4'h5, 4'hA, acc); n_acc += int'(acc);
        send(3'b111, 4'h1, 4'h2, 4'hC, acc); n_acc += int'(acc);
        chk("cap_accepted", n_acc, 5);
        chk("cap_cmd_ready", int'(cmd_ready), 0);
        chk("cap_busy", int'(busy), 1);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset mid-operation: one in RESP, three queued
        rsp_ready = 1'b0;
        send(3'b000, 4'h1, 4'h1, 4'h2, acc);
        send(3'b000, 4'h2, 4'h2, 4'h4, acc);
        send(3'b000, 4'h3, 4'h3, 4'h6, acc);
        send(3'b000, 4'h4, 4'h4, 4'h8, acc);
        chk("pre_rst_rsp_valid", int'(rsp_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_stale", int'(rsp_valid), 0);

        // Self-check flag with a faulty ALU stub
        stub_bug = 1'b1;
        send(3'b011, 4'h3, 4'h4, 4'h0, acc);
        wait_idle();
        stub_bug = 1'b0;
        chk("chk_err_set", int'(chk_err), EXP_CHK);
        send(3'b000, 4'h2, 4'h3, 4'h5, acc);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("chk_err_sticky", int'(chk_err), EXP_CHK);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("chk_err_cleared", int'(chk_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
